// File: rtl/top.sv
// Two-output logic function of three asynchronous inputs.
// Each input is synchronized, then F1/F2 are computed and registered.
module top #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic A,
  input  logic C,
  input  logic D,
  output logic F1,
  output logic F2
);

  logic [SYNC_STAGES-1:0] r_a_sync;
  logic [SYNC_STAGES-1:0] r_c_sync;
  logic [SYNC_STAGES-1:0] r_d_sync;
  logic                   r_f1;
  logic                   r_f2;
  logic                   w_as;
  logic                   w_cs;
  logic                   w_ds;

  assign w_as = r_a_sync[SYNC_STAGES-1];
  assign w_cs = r_c_sync[SYNC_STAGES-1];
  assign w_ds = r_d_sync[SYNC_STAGES-1];

  // Bit 0 is the metastability-exposed capture flop.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_a_sync <= '0;
      r_c_sync <= '0;
      r_d_sync <= '0;
    end else begin
      r_a_sync <= {r_a_sync[SYNC_STAGES-2:0], A};
      r_c_sync <= {r_c_sync[SYNC_STAGES-2:0], C};
      r_d_sync <= {r_d_sync[SYNC_STAGES-2:0], D};
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_f1 <= 1'b0;
      r_f2 <= 1'b0;
    end else begin
      r_f1 <= (w_as & w_cs) | w_ds;
      r_f2 <= w_as ^ w_cs ^ w_ds;
    end
  end

  assign F1 = r_f1;
  assign F2 = r_f2;

endmodule

// File: tb/tb_top.sv
// Bench for top: two DUTs (2 and 3 sync stages) share the same
// inputs and are checked every cycle against a history-based model.
module tb_top;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic A = 1'b0;
  logic C = 1'b0;
  logic D = 1'b0;
  logic f1_2, f2_2, f1_3, f2_3;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  top #(.SYNC_STAGES(2)) u2 (
    .clk(clk), .rst(rst), .A(A), .C(C), .D(D),
    .F1(f1_2), .F2(f2_2)
  );

  top #(.SYNC_STAGES(3)) u3 (
    .clk(clk), .rst(rst), .A(A), .C(C), .D(D),
    .F1(f1_3), .F2(f2_3)
  );

  // Truth table indexed by {A,C,D}, value {F1,F2}.
  logic [1:0] tt [8];
  initial begin
    tt[0] = 2'b00; tt[1] = 2'b11;
    tt[2] = 2'b01; tt[3] = 2'b10;
    tt[4] = 2'b01; tt[5] = 2'b10;
    tt[6] = 2'b10; tt[7] = 2'b11;
  end

  logic [2:0] hist [$];
  int since = 0;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      since = 0;
      hist.delete();
    end else begin
      since++;
      hist.push_back({A, C, D});
      if (hist.size() > 8) void'(hist.pop_front());
    end
  end

  function automatic logic [1:0] model(int n);
    if (rst || since <= n) return 2'b00;
    return tt[hist[hist.size()-1-n]];
  endfunction

  task automatic cmp(string name, logic [1:0] act, logic [1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s t=%0t got %b expected %b",
               name, $time, act, exp);
    end
  endtask

  always @(negedge clk) begin
    cmp("model_s2", {f1_2, f2_2}, model(2));
    cmp("model_s3", {f1_3, f2_3}, model(3));
  end

  task automatic set_in(logic [2:0] v);
    @(posedge clk);
    #3;
    {A, C, D} = v;
  endtask

  task automatic edges(int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  logic [2:0] sweep [8];
  logic [1:0] sweep_exp [8];

  initial begin
    sweep[0] = 3'b000; sweep_exp[0] = 2'b00;
    sweep[1] = 3'b100; sweep_exp[1] = 2'b01;
    sweep[2] = 3'b010; sweep_exp[2] = 2'b01;
    sweep[3] = 3'b110; sweep_exp[3] = 2'b10;
    sweep[4] = 3'b001; sweep_exp[4] = 2'b11;
    sweep[5] = 3'b101; sweep_exp[5] = 2'b10;
    sweep[6] = 3'b011; sweep_exp[6] = 2'b10;
    sweep[7] = 3'b111; sweep_exp[7] = 2'b11;

    #2;
    cmp("reset_s2", {f1_2, f2_2}, 2'b00);
    cmp("reset_s3", {f1_3, f2_3}, 2'b00);
    repeat (2) @(posedge clk);
    #7 rst = 1'b0;

    // Truth-table sweep with latency 3 / 4 edges.
    for (int i = 0; i < 8; i++) begin
      set_in(sweep[i]);
      edges(3);
      cmp($sformatf("sweep_s2_%0d", i),
          {f1_2, f2_2}, sweep_exp[i]);
      edges(1);
      cmp($sformatf("sweep_s3_%0d", i),
          {f1_3, f2_3}, sweep_exp[i]);
      edges(6);
    end

    // Latency: 000 -> 110.
    set_in(3'b000);
    edges(6);
    set_in(3'b110);
    edges(1);
    cmp("lat_e1", {f1_2, f2_2}, 2'b00);
    edges(1);
    cmp("lat_e2", {f1_2, f2_2}, 2'b00);
    edges(1);
    cmp("lat_e3", {f1_2, f2_2}, 2'b10);

    // Async reset pulse with ACD=111.
    set_in(3'b111);
    edges(6);
    cmp("pre_rst", {f1_2, f2_2}, 2'b11);
    @(posedge clk);
    #3 rst = 1'b1;
    #1;
    cmp("async_s2", {f1_2, f2_2}, 2'b00);
    cmp("async_s3", {f1_3, f2_3}, 2'b00);
    #3 rst = 1'b0;
    edges(2);
    cmp("rel_e2", {f1_2, f2_2}, 2'b00);
    edges(1);
    cmp("rel_e3", {f1_2, f2_2}, 2'b11);
    edges(1);
    cmp("rel_e4_s3", {f1_3, f2_3}, 2'b11);

    // Reset mid-flight: 000 -> 001, reset one edge later.
    set_in(3'b000);
    edges(6);
    set_in(3'b001);
    @(posedge clk);
    #3 rst = 1'b1;
    #4 rst = 1'b0;
    edges(2);
    cmp("mid_e2", {f1_2, f2_2}, 2'b00);
    edges(1);
    cmp("mid_e3", {f1_2, f2_2}, 2'b11);

    // Simultaneous change 100 -> 011.
    set_in(3'b100);
    edges(6);
    cmp("sim_pre", {f1_2, f2_2}, 2'b01);
    set_in(3'b011);
    edges(2);
    cmp("sim_e2", {f1_2, f2_2}, 2'b01);
    edges(1);
    cmp("sim_e3", {f1_2, f2_2}, 2'b10);

    // Randomized inputs and occasional resets.
    for (int i = 0; i < 600; i++) begin
      @(posedge clk);
      #3;
      if ($urandom_range(0, 2) == 0)
        {A, C, D} = 3'($urandom_range(0, 7));
      if ($urandom_range(0, 60) == 0) begin
        rst = 1'b1;
        #4 rst = 1'b0;
      end
    end

    edges(2);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/top.md
TOP -- requirements
Module: top

Interface
REQ-001 Parameter SYNC_STAGES, default 2: number of synchronizer flops per input; legal range 2..4.
REQ-002 clk  input  1  single system clock; all state updates on the rising edge.
REQ-003 rst  input  1  asynchronous active-high reset.
REQ-004 A  input  1  logic input; asynchronous to clk and may change at any time.
REQ-005 C  input  1  logic input; asynchronous to clk and may change at any time.
REQ-006 D  input  1  logic input; asynchronous to clk and may change at any time.
REQ-007 F1  output  1  registered logic function F1 of A, C, D.
REQ-008 F2  output  1  registered logic function F2 of A, C, D.
REQ-009 The block SHALL have one clock (clk) and an asynchronous, active-high reset (rst), with no other clock or reset inputs.

Function
REQ-010 Each of A, C and D SHALL pass through its own chain of SYNC_STAGES flops before any logic uses it.
REQ-011 Synchronized values are called As, Cs and Ds.
REQ-012 F1 SHALL be the registered value of (As AND Cs) OR Ds.
REQ-013 F2 SHALL be the registered value of As XOR Cs XOR Ds (odd parity).
REQ-014 F1 and F2 SHALL each be driven directly by one output flop, with no combinational path from any input to any output.
REQ-015 Latency SHALL be SYNC_STAGES+1 rising edges from a stable input change to the matching output change (3 edges at default).
REQ-016 When several inputs change between the same two clock edges, the outputs SHALL move directly to the value for the new input combination.
REQ-017 When an input change meets setup/hold at the same edge, the outputs SHALL reflect either the old or the new input combination, one cycle apart, and SHALL never show a combination that never existed at the inputs for more than one cycle.
REQ-018 Inputs held stable SHALL give constant outputs, with no glitches on F1 or F2.
REQ-019 The complete truth table (A C D -> F1 F2) SHALL be:
  000->00, 100->01, 010->01, 110->10, 001->11, 101->10, 011->10, 111->11.
REQ-020 The block SHALL contain no other state, counters or internal FSM.

Reset
REQ-021 While rst=1, every synchronizer flop and both output flops SHALL clear to 0 immediately, without waiting for clk, so F1=0 and F2=0.
REQ-022 After rst is deasserted, the outputs SHALL follow REQ-015 latency starting at the first rising edge of clk.
REQ-023 Asserting rst mid-operation SHALL discard all in-flight synchronizer values.
REQ-024 The outputs SHALL NOT reflect any pre-reset input change after reset is released; only input values sampled after release SHALL reach F1 and F2.

Verification
REQ-025 Truth-table sweep: clk period 10 ns; step A,C,D through 000, 100, 010, 110, 001, 101, 011, 111, holding each for 100 ns -> F1/F2 settle to 00, 01, 01, 10, 11, 10, 10, 11 respectively within 3 clk edges of each step.
REQ-026 Latency check: from ACD=000 (outputs 00), set ACD=110 just after an edge -> F1 stays 0 for 2 edges, then goes to 1 on the 3rd edge, while F2 stays 0 throughout.
REQ-027 Async reset: with ACD=111 and F1F2=11, pulse rst between edges -> F1F2=00 immediately; after release with ACD still 111, F1F2=11 on the 3rd edge.
REQ-028 Reset mid-flight: change ACD 000->001, assert rst one edge later, then release -> F1F2 stays 00 until 3 edges after release, then becomes 11.
REQ-029 Simultaneous change: switch ACD 100->011 between two edges -> F1F2 goes directly 01->10, with no intermediate code appearing.
REQ-030 Parameter: run with SYNC_STAGES=3 -> latency for the sweep in REQ-025 is 4 edges, and the truth table is unchanged.
